// File: rtl/axi_dw_downsize_rd_seq.sv
// Read-side sequencer of the AXI data-width downsizer: splits one wide AR into
// narrow AR bursts and steers returning narrow R beats into wide-beat lanes.
module axi_dw_downsize_rd_seq #(
    parameter int unsigned AxiAddrWidth        = 32,
    parameter int unsigned AxiSlvPortDataWidth = 64,
    parameter int unsigned AxiMstPortDataWidth = 32,
    localparam int unsigned SlvLog = $clog2(AxiSlvPortDataWidth / 8),
    localparam int unsigned MstLog = $clog2(AxiMstPortDataWidth / 8),
    localparam int unsigned LaneW  = (SlvLog - MstLog > 1) ? SlvLog - MstLog : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    slv_ar_valid_i,
    output logic                    slv_ar_ready_o,
    input  logic [AxiAddrWidth-1:0] slv_ar_addr_i,
    input  logic [7:0]              slv_ar_len_i,
    input  logic [2:0]              slv_ar_size_i,
    input  logic [1:0]              slv_ar_burst_i,
    output logic                    mst_ar_valid_o,
    input  logic                    mst_ar_ready_i,
    output logic [AxiAddrWidth-1:0] mst_ar_addr_o,
    output logic [7:0]              mst_ar_len_o,
    output logic [2:0]              mst_ar_size_o,
    input  logic                    mst_r_valid_i,
    output logic                    mst_r_ready_o,
    output logic                    slv_r_valid_o,
    input  logic                    slv_r_ready_i,
    output logic                    slv_r_last_o,
    output logic                    slv_r_err_o,
    output logic [LaneW-1:0]        r_lane_sel_o,
    output logic                    r_lane_we_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, DATA, ERR} state_e;

    state_e                  state_q;
    logic                    ar_ready_q;
    logic [7:0]              len_q;
    logic                    pt_q;
    logic [LaneW-1:0]        kmask_q;
    logic [9:0]              rem_q;
    logic [8:0]              chunk_cnt_q;
    logic [AxiAddrWidth-1:0] ca_q;
    logic [7:0]              wide_cnt_q;
    logic [AxiAddrWidth-1:0] mst_ar_addr_q;
    logic [7:0]              mst_ar_len_q;
    logic [2:0]              mst_ar_size_q;

    // Decode of the incoming wide command
    logic             cmd_pt;
    logic [2:0]       cmd_sh;
    logic [LaneW-1:0] cmd_kmask;
    logic [LaneW-1:0] cmd_off;
    logic [15:0]      cmd_beats;
    logic [9:0]       cmd_total;
    logic             cmd_err;

    always_comb begin
        cmd_pt    = slv_ar_size_i <= 3'(MstLog);
        cmd_sh    = cmd_pt ? 3'd0 : slv_ar_size_i - 3'(MstLog);
        cmd_kmask = LaneW'((32'd1 << cmd_sh) - 32'd1);
        cmd_off   = slv_ar_addr_i[SlvLog-1:MstLog] & cmd_kmask;
        cmd_beats = (16'(slv_ar_len_i) + 16'd1) << cmd_sh;
        cmd_total = 10'(cmd_beats - 16'(cmd_off));
        cmd_err   = (slv_ar_burst_i == 2'b10) ||
                    (slv_ar_burst_i == 2'b00 && slv_ar_len_i != 8'd0);
    end

    logic [AxiAddrWidth-1:0] beat_step;
    logic [AxiAddrWidth-1:0] beat_mask;
    logic [AxiAddrWidth-1:0] next_chunk_addr;
    logic [LaneW-1:0]        lane;
    logic                    cmp;
    logic                    in_data;
    logic                    in_err;
    logic                    slv_hs;
    logic                    mst_hs;

    always_comb begin
        beat_step       = AxiAddrWidth'(1) << mst_ar_size_q;
        beat_mask       = beat_step - AxiAddrWidth'(1);
        next_chunk_addr = (mst_ar_addr_q & ~beat_mask) + (beat_step << 8);
        lane            = ca_q[SlvLog-1:MstLog];
        in_data         = state_q == DATA;
        in_err          = state_q == ERR;
        // A narrow beat closes a wide beat at the top lane of the wide word or at the very end
        cmp             = pt_q || ((lane & kmask_q) == kmask_q) ||
                          (rem_q == 10'd0 && chunk_cnt_q == 9'd1);
        slv_r_valid_o   = (in_data & mst_r_valid_i & cmp) | in_err;
        mst_r_ready_o   = in_data & (~cmp | slv_r_ready_i);
        r_lane_we_o     = mst_r_valid_i & mst_r_ready_o;
        slv_r_last_o    = ((in_data & cmp) | in_err) & (wide_cnt_q == len_q);
        slv_r_err_o     = in_err;
        r_lane_sel_o    = in_data ? lane : '0;
        slv_hs          = slv_r_valid_o & slv_r_ready_i;
        mst_hs          = mst_r_valid_i & mst_r_ready_o;
    end

    assign slv_ar_ready_o = ar_ready_q;
    assign mst_ar_valid_o = state_q == ISSUE;
    assign mst_ar_addr_o  = mst_ar_addr_q;
    assign mst_ar_len_o   = mst_ar_len_q;
    assign mst_ar_size_o  = mst_ar_size_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            ar_ready_q    <= 1'b0;
            len_q         <= '0;
            pt_q          <= 1'b0;
            kmask_q       <= '0;
            rem_q         <= '0;
            chunk_cnt_q   <= '0;
            ca_q          <= '0;
            wide_cnt_q    <= '0;
            mst_ar_addr_q <= '0;
            mst_ar_len_q  <= '0;
            mst_ar_size_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ar_ready_q && slv_ar_valid_i) begin
                        ar_ready_q    <= 1'b0;
                        len_q         <= slv_ar_len_i;
                        pt_q          <= cmd_pt;
                        kmask_q       <= cmd_pt ? '0 : cmd_kmask;
                        rem_q         <= cmd_total;
                        chunk_cnt_q   <= '0;
                        wide_cnt_q    <= '0;
                        mst_ar_addr_q <= slv_ar_addr_i;
                        mst_ar_size_q <= cmd_pt ? slv_ar_size_i : 3'(MstLog);
                        mst_ar_len_q  <= (cmd_total > 10'd256) ? 8'd255 : 8'(cmd_total - 10'd1);
                        state_q       <= cmd_err ? ERR : ISSUE;
                    end else begin
                        ar_ready_q <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (mst_ar_ready_i) begin
                        chunk_cnt_q <= 9'(mst_ar_len_q) + 9'd1;
                        rem_q       <= rem_q - (10'(mst_ar_len_q) + 10'd1);
                        ca_q        <= mst_ar_addr_q;
                        state_q     <= DATA;
                    end
                end
                DATA: begin
                    if (slv_hs) wide_cnt_q <= wide_cnt_q + 8'd1;
                    if (mst_hs) begin
                        chunk_cnt_q <= chunk_cnt_q - 9'd1;
                        ca_q        <= (ca_q & ~beat_mask) + beat_step;
                        if (chunk_cnt_q == 9'd1) begin
                            if (rem_q != 10'd0) begin
                                mst_ar_addr_q <= next_chunk_addr;
                                mst_ar_len_q  <= (rem_q > 10'd256) ? 8'd255 : 8'(rem_q - 10'd1);
                                state_q       <= ISSUE;
                            end else begin
                                ar_ready_q <= 1'b1;
                                state_q    <= IDLE;
                            end
                        end
                    end
                end
                ERR: begin
                    if (slv_r_ready_i) begin
                        wide_cnt_q <= wide_cnt_q + 8'd1;
                        if (wide_cnt_q == len_q) begin
                            ar_ready_q <= 1'b1;
                            state_q    <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
